// File: rtl/multicycle_control_fsm.sv
// Multicycle RV32I main control FSM: fetch/decode/execute sequencing,
// memory handshake, sticky illegal-opcode flag and retired counter.
module multicycle_control_fsm #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      instruction_code,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             ir_write,
  output logic             adr_src,
  output logic             mem_read,
  output logic             mem_write,
  output logic             reg_write,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       ALUOp,
  output logic [1:0]       result_src,
  output logic [3:0]       state,
  output logic             illegal_op,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_ALUWB    = 4'd7,
    S_BEQ      = 4'd8
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic             r_ill;
  logic [CNT_W-1:0] r_ret;

  logic [6:0] w_op;
  logic       w_unused;
  logic       w_is_mem;
  logic       w_is_r;
  logic       w_is_beq;
  logic       w_bad_op;
  logic       w_retire;

  logic       w_pcw, w_irw, w_adr;
  logic       w_mrd, w_mwr, w_rw;
  logic [1:0] w_sa, w_sb, w_op2, w_rs;

  assign w_op     = instruction_code[6:0];
  assign w_unused = ^instruction_code[31:7];
  assign w_is_mem = (w_op == 7'b0000011) || (w_op == 7'b0100011);
  assign w_is_r   = (w_op == 7'b0110011);
  assign w_is_beq = (w_op == 7'b1100011);
  assign w_bad_op = (r_state == S_DECODE) &&
                    !(w_is_mem || w_is_r || w_is_beq);

  always_comb begin
    w_next = S_FETCH;
    w_pcw  = 1'b0;
    w_irw  = 1'b0;
    w_adr  = 1'b0;
    w_mrd  = 1'b0;
    w_mwr  = 1'b0;
    w_rw   = 1'b0;
    w_sa   = 2'b00;
    w_sb   = 2'b00;
    w_op2  = 2'b00;
    w_rs   = 2'b00;
    w_retire = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_mrd  = 1'b1;
        w_sb   = 2'b10;
        w_rs   = 2'b10;
        w_irw  = mem_ready;
        w_pcw  = mem_ready;
        w_next = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        w_sa = 2'b01;
        w_sb = 2'b01;
        unique case (1'b1)
          w_is_mem: w_next = S_MEMADR;
          w_is_r:   w_next = S_EXECR;
          w_is_beq: w_next = S_BEQ;
          default:  w_next = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        w_sa   = 2'b10;
        w_sb   = 2'b01;
        w_next = w_op[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        w_mrd  = 1'b1;
        w_adr  = 1'b1;
        w_next = mem_ready ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWB: begin
        w_rs     = 2'b01;
        w_rw     = 1'b1;
        w_retire = 1'b1;
      end
      S_MEMWRITE: begin
        w_mwr    = 1'b1;
        w_adr    = 1'b1;
        w_retire = mem_ready;
        w_next   = mem_ready ? S_FETCH : S_MEMWRITE;
      end
      S_EXECR: begin
        w_sa   = 2'b10;
        w_op2  = 2'b10;
        w_next = S_ALUWB;
      end
      S_ALUWB: begin
        w_rw     = 1'b1;
        w_retire = 1'b1;
      end
      S_BEQ: begin
        w_sa     = 2'b10;
        w_op2    = 2'b01;
        w_pcw    = zero;
        w_retire = 1'b1;
      end
      default: w_next = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_FETCH;
      r_ill   <= 1'b0;
      r_ret   <= '0;
    end else begin
      r_state <= w_next;
      if (w_bad_op) r_ill <= 1'b1;
      if (w_retire) r_ret <= r_ret + CNT_W'(1);
    end
  end

  // Reset is asynchronous, so strobes are masked combinationally too.
  assign pc_write   = rst_n & w_pcw;
  assign ir_write   = rst_n & w_irw;
  assign adr_src    = rst_n & w_adr;
  assign mem_read   = rst_n & w_mrd;
  assign mem_write  = rst_n & w_mwr;
  assign reg_write  = rst_n & w_rw;
  assign alu_src_a  = rst_n ? w_sa  : 2'b00;
  assign alu_src_b  = rst_n ? w_sb  : 2'b00;
  assign ALUOp      = rst_n ? w_op2 : 2'b00;
  assign result_src = rst_n ? w_rs  : 2'b00;
  assign state      = r_state;
  assign illegal_op = r_ill;
  assign retired    = r_ret;

endmodule

// File: doc/multicycle_control_fsm.md
# multicycle_control_fsm

Main control state machine for the multicycle RV32I datapath. It sequences fetch, decode, execute, memory and writeback for R-type, lw, sw and beq. It drives the datapath enables and mux selects, and produces `ALUOp[1:0]`, which the downstream ALU control decoder turns into the 4-bit ALU operation code. It also handshakes with the unified instruction/data memory and keeps a retired-instruction counter.

## Interface
Parameters:
- `CNT_W`, default 32: width of the retired-instruction counter.

Ports:
- `clk`  in  1: single clock; all state changes on its rising edge.
- `rst_n`  in  1: reset, asynchronous and active-low.
- `instruction_code`  in  32: current instruction from the instruction register; only `[6:0]` (opcode) is decoded.
- `zero`  in  1: ALU zero flag.
- `mem_ready`  in  1: memory completes the current read/write this cycle.
- `pc_write`  out  1: PC register load enable.
- `ir_write`  out  1: instruction register load enable.
- `adr_src`  out  1: memory address select; 0 = PC, 1 = ALUOut.
- `mem_read`  out  1: memory read request.
- `mem_write`  out  1: memory write request.
- `reg_write`  out  1: register file write enable.
- `alu_src_a`  out  2: ALU A operand select; 00 = PC, 01 = old PC, 10 = rs1.
- `alu_src_b`  out  2: ALU B operand select; 00 = rs2, 01 = immediate, 10 = constant 4.
- `ALUOp`  out  2: to ALU control; 00 = add, 01 = subtract/compare, 10 = funct decode.
- `result_src`  out  2: result select; 00 = ALUOut, 01 = memory data, 10 = ALU result direct.
- `state`  out  4: current state encoding, for debug.
- `illegal_op`  out  1: sticky flag, set on an unsupported opcode.
- `retired`  out  CNT_W: count of completed instructions.

## Operation
- State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, ALUWB=7, BEQ=8. Values 9–15 are unreachable; if reached, the next state is FETCH.
- Outputs are decoded from `state`. `pc_write` and `ir_write` additionally depend on `mem_ready`/`zero`, as noted below. Any output not listed for a state is 0.
- FETCH:
  - Drives `mem_read`=1, `adr_src`=0, `alu_src_a`=00, `alu_src_b`=10, `ALUOp`=00, `result_src`=10.
  - `ir_write` = `pc_write` = `mem_ready`.
  - Goes to DECODE on `mem_ready`; otherwise stays in FETCH.
- DECODE:
  - Drives `alu_src_a`=01, `alu_src_b`=01, `ALUOp`=00 (branch target into ALUOut).
  - Next state by opcode: 0000011 or 0100011 → MEMADR; 0110011 → EXECR; 1100011 → BEQ.
  - Any other opcode → FETCH, with `illegal_op` set to 1 and `retired` unchanged.
- MEMADR:
  - Drives `alu_src_a`=10, `alu_src_b`=01, `ALUOp`=00.
  - Goes to MEMREAD if opcode bit 5 = 0, otherwise to MEMWRITE.
- MEMREAD:
  - Drives `mem_read`=1, `adr_src`=1.
  - Goes to MEMWB on `mem_ready`; otherwise stays.
- MEMWB:
  - Drives `result_src`=01, `reg_write`=1.
  - Goes to FETCH.
- MEMWRITE:
  - Drives `mem_write`=1, `adr_src`=1.
  - Goes to FETCH on `mem_ready`; otherwise stays.
- EXECR:
  - Drives `alu_src_a`=10, `alu_src_b`=00, `ALUOp`=10.
  - Goes to ALUWB.
- ALUWB:
  - Drives `result_src`=00, `reg_write`=1.
  - Goes to FETCH.
- BEQ:
  - Drives `alu_src_a`=10, `alu_src_b`=00, `ALUOp`=01, `result_src`=00, `pc_write`=`zero`.
  - Goes to FETCH.
- `retired` increments by 1, wrapping modulo 2^CNT_W, on every transition into FETCH from MEMWB, MEMWRITE, ALUWB or BEQ.
- `illegal_op` is cleared only by reset.

## Timing
- Reset (`rst_n` low):
  - Immediately: `state`=FETCH, `retired`=0, `illegal_op`=0.
  - While `rst_n` is low, all enables and requests (`pc_write`, `ir_write`, `mem_read`, `mem_write`, `reg_write`) are forced to 0, and all selects and `ALUOp` are 0.
  - The first `mem_read` appears in the first cycle after `rst_n` goes high.
  - Reset mid-instruction abandons it with no write strobes and no `retired` increment.
- Cycle counts with `mem_ready` high on the first request cycle:
  - R-type: 4 cycles.
  - lw: 5 cycles.
  - sw: 4 cycles.
  - beq: 3 cycles.
  - Each wait cycle on `mem_ready` adds 1.
- Memory handshake:
  - `mem_read`/`mem_write` stay asserted, with a stable `adr_src`, until the cycle in which `mem_ready`=1.
  - `mem_ready` is ignored in non-memory states.
- `ir_write` and `pc_write` in FETCH pulse for exactly the one cycle in which `mem_ready`=1.
- `instruction_code` is sampled only in DECODE and MEMADR.

## Test plan
- Reset held low for 3 cycles, then released: `state`=0, all strobes 0, `retired`=0 while low; `mem_read`=1 in the first cycle after release.
- R-type 0x002081B3 with `mem_ready` tied high: states 0,1,6,7,0; `ALUOp`=10 in EXECR; `reg_write`=1 only in ALUWB; `retired`=1 after.
- lw 0x0000A183 with 2 wait cycles on the data read: `mem_read`=1 with `adr_src`=1 held for 3 cycles; state sequence 0,1,2,3,3,3,4,0; 7 cycles total.
- beq with `zero`=1, then beq with `zero`=0: `pc_write`=1 in BEQ only for the first; `ALUOp`=01 in both; `retired` += 2.
- Opcode 0x7F: DECODE → FETCH, `illegal_op`=1 and stays 1 across the next valid instruction; `retired` unchanged for the illegal instruction.
- `rst_n` asserted during MEMWRITE while waiting on `mem_ready`: `mem_write` drops immediately, `state`=0, `retired`=0.
